// File: rtl/sfx_tone_sequencer_if.sv
// Codec sample handshake between Audio_Controller and the tone sequencer.
// master: controller side (availability, input samples); slave: sequencer side.
interface sfx_tone_sequencer_if #(
  parameter int SAMPLE_WIDTH = 32
);
  logic                    audio_in_available;
  logic                    audio_out_allowed;
  logic [SAMPLE_WIDTH-1:0] left_in;
  logic [SAMPLE_WIDTH-1:0] right_in;
  logic                    read_audio_in;
  logic                    write_audio_out;
  logic [SAMPLE_WIDTH-1:0] left_out;
  logic [SAMPLE_WIDTH-1:0] right_out;

  modport master (
    output audio_in_available,
    output audio_out_allowed,
    output left_in,
    output right_in,
    input  read_audio_in,
    input  write_audio_out,
    input  left_out,
    input  right_out
  );

  modport slave (
    input  audio_in_available,
    input  audio_out_allowed,
    input  left_in,
    input  right_in,
    output read_audio_in,
    output write_audio_out,
    output left_out,
    output right_out
  );
endinterface

// File: rtl/sfx_tone_sequencer.sv
// Hit/miss/time-up square-wave effects mixed into codec pass-through audio.
// Define SFX_SATURATE_EN to clamp channel sums instead of wrapping them.
module sfx_tone_sequencer #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int AMPLITUDE    = 10000000,
  parameter int GAP_TICKS    = 5000000,
  parameter int ON_TICKS     = 5000000,
  parameter int HP_WIDTH     = 19,
  parameter int HP_LOW       = 191131,
  parameter int HP_MID       = 151653,
  parameter int HP_HIGH      = 95547
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       trigger,
  input  logic [1:0] sfx_id,
  input  logic       stop,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_idx,
  sfx_tone_sequencer_if.slave aud
);

  localparam int W    = SAMPLE_WIDTH;
  localparam int CMAX = (GAP_TICKS > ON_TICKS) ? GAP_TICKS : ON_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] GAP_END = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0] ON_END  = CW'(ON_TICKS - 1);

  localparam logic [W-1:0] AMP_P = W'(AMPLITUDE);
  localparam logic [W-1:0] AMP_N = W'(-AMPLITUDE);

  localparam logic [1:0] ID_HIT  = 2'd0;
  localparam logic [1:0] ID_MISS = 2'd1;
  localparam logic [1:0] ID_TUP  = 2'd2;
  localparam logic [1:0] ID_RSV  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_TONE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          id_q, id_d;
  logic                done_q, done_d;
  logic [HP_WIDTH-1:0] hp_q, hp_d;
  logic                phase_q, phase_d;
  logic [W-1:0]        tone_q, tone_d;

  logic                start;
  logic                gap_end;
  logic                on_end;
  logic                sel_high;
  logic                sel_mid;
  logic [HP_WIDTH-1:0] hp_lim;

  assign start   = trigger && (sfx_id != ID_RSV) && !stop;
  assign gap_end = (cnt_q == GAP_END);
  assign on_end  = (cnt_q == ON_END);

  // Hit plays H,M,L; miss plays L,M,H; time-up is all L.
  assign sel_high = ((id_q == ID_HIT) && (idx_q == 2'd0)) ||
                    ((id_q == ID_MISS) && (idx_q == 2'd2));
  assign sel_mid  = (id_q != ID_TUP) && (idx_q == 2'd1);

  always_comb begin
    hp_lim = HP_WIDTH'(HP_LOW);
    unique case (1'b1)
      sel_high: hp_lim = HP_WIDTH'(HP_HIGH);
      sel_mid:  hp_lim = HP_WIDTH'(HP_MID);
      default:  hp_lim = HP_WIDTH'(HP_LOW);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    id_d    = id_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = 2'd0;
          id_d    = sfx_id;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = 2'd0;
          id_d    = sfx_id;
        end else if (gap_end) begin
          state_d = S_TONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TONE: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = 2'd0;
          id_d    = sfx_id;
        end else if (on_end) begin
          cnt_d = '0;
          if (idx_q != 2'd2) begin
            state_d = S_GAP;
            idx_d   = idx_q + 2'd1;
          end else if (id_q == ID_TUP) begin
            state_d = S_GAP;
            idx_d   = 2'd0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Half-period divider only advances while staying in TONE.
  always_comb begin
    hp_d    = '0;
    phase_d = 1'b0;
    tone_d  = '0;
    if ((state_q == S_TONE) && (state_d == S_TONE)) begin
      if (hp_q == hp_lim) begin
        hp_d    = '0;
        phase_d = ~phase_q;
      end else begin
        hp_d    = hp_q + HP_WIDTH'(1);
        phase_d = phase_q;
      end
    end
    if (state_d == S_TONE) begin
      tone_d = phase_d ? AMP_N : AMP_P;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      id_q    <= 2'd0;
      done_q  <= 1'b0;
      hp_q    <= '0;
      phase_q <= 1'b0;
      tone_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      done_q  <= done_d;
      hp_q    <= hp_d;
      phase_q <= phase_d;
      tone_q  <= tone_d;
    end
  end

  function automatic logic [W-1:0] mix(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] s;
    s = a + b;
`ifdef SFX_SATURATE_EN
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
      s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
    s = a + b;
`endif
    return s;
  endfunction

  assign aud.read_audio_in   = aud.audio_in_available & aud.audio_out_allowed;
  assign aud.write_audio_out = aud.audio_in_available & aud.audio_out_allowed;
  assign aud.left_out        = mix(aud.left_in, tone_q);
  assign aud.right_out       = mix(aud.right_in, tone_q);

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Directed bench for sfx_tone_sequencer: vector table plus retrigger,
// overflow and async-reset sequences.
module tb_sfx_tone_sequencer;

  logic       CLOCK_50;
  logic       resetn;
  logic       trigger;
  logic [1:0] sfx_id;
  logic       stop;
  logic       busy;
  logic       done;
  logic [1:0] note_idx;

  int n_cmp;
  int n_bad;

  sfx_tone_sequencer_if #(.SAMPLE_WIDTH(16)) aud ();

  sfx_tone_sequencer #(
    .SAMPLE_WIDTH(16),
    .AMPLITUDE   (100),
    .GAP_TICKS   (4),
    .ON_TICKS    (8),
    .HP_WIDTH    (4),
    .HP_LOW      (3),
    .HP_MID      (2),
    .HP_HIGH     (1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .trigger (trigger),
    .sfx_id  (sfx_id),
    .stop    (stop),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx),
    .aud     (aud)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic              trig;
    logic [1:0]        id;
    logic              stop;
    logic signed [15:0] lin;
    logic              avail;
    logic              allow;
    int                adv;
    logic              busy;
    logic [1:0]        idx;
    logic signed [15:0] lout;
    logic              done;
    logic              rdwr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic t, input logic [1:0] id, input logic s,
    input int lin, input int adv,
    input logic b, input logic [1:0] ix,
    input int lo, input logic d
  );
    vec_t r;
    r.trig = t; r.id = id; r.stop = s;
    r.lin = 16'(lin); r.avail = 1'b1; r.allow = 1'b1;
    r.adv = adv; r.busy = b; r.idx = ix;
    r.lout = 16'(lo); r.done = d; r.rdwr = 1'b1;
    return r;
  endfunction

  function automatic vec_t hs(input logic av, input logic al);
    vec_t r;
    r = v(1'b0, 2'd0, 1'b0, 0, 0, 1'b0, 2'd0, 0, 1'b0);
    r.avail = av; r.allow = al; r.rdwr = av & al;
    return r;
  endfunction

  task automatic check(input string nm,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  int done_cnt;
  int done_at;
  logic signed [15:0] exp_pos;
  logic signed [15:0] exp_neg;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    trigger = 1'b0;
    sfx_id = 2'd0;
    stop = 1'b0;
    aud.audio_in_available = 1'b1;
    aud.audio_out_allowed = 1'b1;
    aud.left_in = 16'sd0;
    aud.right_in = 16'sd0;

    // hit
    tv.push_back(v(1, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 1, 0, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 2, 1, 0, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 2, 1, 0, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 4, 1, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 4, 1, 1, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 3, 1, 1, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 3, 1, 1, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 2, 1, 2, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 4, 1, 2, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 4, 1, 2, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 3, 1, 2, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 2, 0, 1));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 2, 0, 0));
    // miss
    tv.push_back(v(1, 1, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 4, 1, 0, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 3, 1, 0, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 1, 0, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 8, 1, 1, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 3, 1, 1, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 9, 1, 2, 100, 0));
    tv.push_back(v(0, 0, 0, 0, 2, 1, 2, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 6, 0, 2, 0, 1));
    // time-up loops, then stop
    tv.push_back(v(1, 2, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 35, 1, 2, -100, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 24, 1, 2, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 12, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 24, 1, 2, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 12, 1, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 4, 1, 0, 100, 0));
    tv.push_back(v(0, 2, 1, 1234, 1, 0, 0, 1234, 0));
    // stop+trigger collision, reserved id
    tv.push_back(v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(v(1, 3, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 2, 0, 0, 0, 0));
    // handshake
    tv.push_back(hs(1'b1, 1'b0));
    tv.push_back(hs(1'b1, 1'b1));
    tv.push_back(hs(1'b0, 1'b1));
    tv.push_back(hs(1'b0, 1'b0));
    // mixing
    tv.push_back(v(1, 0, 0, 500, 5, 1, 0, 600, 0));
    tv.push_back(v(0, 0, 1, 500, 1, 0, 0, 500, 0));

    #2;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst idx", note_idx, 2'd0);
    check("rst lout", $signed(aud.left_out), 0);
    step();
    step();
    resetn = 1'b1;
    step();
    check("post-rst busy", busy, 1'b0);
    check("post-rst lout", $signed(aud.left_out), 0);

    foreach (tv[i]) begin
      trigger = tv[i].trig;
      sfx_id = tv[i].id;
      stop = tv[i].stop;
      aud.left_in = tv[i].lin;
      aud.right_in = tv[i].lin;
      aud.audio_in_available = tv[i].avail;
      aud.audio_out_allowed = tv[i].allow;
      if (tv[i].adv > 0) begin
        step();
        trigger = 1'b0;
        for (int k = 1; k < tv[i].adv; k++) step();
      end
      #1;
      check($sformatf("v%0d busy", i), busy, tv[i].busy);
      check($sformatf("v%0d idx", i), note_idx, tv[i].idx);
      check($sformatf("v%0d lout", i), $signed(aud.left_out), tv[i].lout);
      check($sformatf("v%0d rout", i), $signed(aud.right_out), tv[i].lout);
      check($sformatf("v%0d done", i), done, tv[i].done);
      check($sformatf("v%0d rd", i), aud.read_audio_in, tv[i].rdwr);
      check($sformatf("v%0d wr", i), aud.write_audio_out, tv[i].rdwr);
    end

    // retrigger a hit with a miss at clock 20
    stop = 1'b0;
    aud.left_in = 16'sd0;
    aud.right_in = 16'sd0;
    aud.audio_in_available = 1'b1;
    aud.audio_out_allowed = 1'b1;
    done_cnt = 0;
    done_at = -1;
    trigger = 1'b1;
    sfx_id = 2'd0;
    step();
    trigger = 1'b0;
    if (done) done_cnt++;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (done) done_cnt++;
    end
    check("rt pre idx", note_idx, 2'd1);
    check("rt pre lout", $signed(aud.left_out), -100);
    trigger = 1'b1;
    sfx_id = 2'd1;
    step();
    trigger = 1'b0;
    check("rt idx", note_idx, 2'd0);
    check("rt busy", busy, 1'b1);
    check("rt gap lout", $signed(aud.left_out), 0);
    if (done) done_cnt++;
    for (int k = 2; k <= 40; k++) begin
      step();
      if (k == 5) check("rt miss L", $signed(aud.left_out), 100);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    check("rt done count", done_cnt, 1);
    check("rt done clock", done_at, 37);
    check("rt end busy", busy, 1'b0);

    // overflow, then async reset mid-TONE
`ifdef SFX_SATURATE_EN
    exp_pos = 16'sd32767;
    exp_neg = -16'sd32768;
`else
    exp_pos = -16'sd32676;
    exp_neg = 16'sd32676;
`endif
    aud.left_in = 16'sd32760;
    aud.right_in = 16'sd32760;
    trigger = 1'b1;
    sfx_id = 2'd0;
    step();
    trigger = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    check("ovf pos l", $signed(aud.left_out), exp_pos);
    check("ovf pos r", $signed(aud.right_out), exp_pos);
    step();
    step();
    aud.left_in = -16'sd32760;
    aud.right_in = -16'sd32760;
    #1;
    check("ovf neg l", $signed(aud.left_out), exp_neg);
    resetn = 1'b0;
    #1;
    check("arst busy", busy, 1'b0);
    check("arst lout", $signed(aud.left_out), -32760);
    check("arst idx", note_idx, 2'd0);
    step();
    check("arst hold busy", busy, 1'b0);
    #2;
    resetn = 1'b1;
    step();
    check("arst rel busy", busy, 1'b0);
    check("arst rel done", done, 1'b0);
    check("arst rel lout", $signed(aud.left_out), -32760);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
